// File: rtl/sram_1p_bm_mbist.sv
// Single-port SRAM behavioural model with per-bit write mask, write-through,
// an integrated March C- BIST engine and single-bit stuck-at-1 fault injection.
module sram_1p_bm_mbist #(
   parameter int P_DATA_WIDTH = 24,
   parameter int P_ADDR_WIDTH = 14,
   parameter int P_DEPTH      = 2**P_ADDR_WIDTH
) (
   input  logic                            A_CLK,
   input  logic                            A_RST_N,
   input  logic [P_ADDR_WIDTH-1:0]         A_ADDR,
   input  logic [P_DATA_WIDTH-1:0]         A_DIN,
   input  logic [P_DATA_WIDTH-1:0]         A_BM,
   input  logic                            A_MEN,
   input  logic                            A_WEN,
   input  logic                            A_REN,
   input  logic                            A_DLY,
   output logic [P_DATA_WIDTH-1:0]         A_DOUT,
   input  logic                            A_BIST_START,
   output logic                            A_BIST_BUSY,
   output logic                            A_BIST_DONE,
   output logic                            A_BIST_FAIL,
   output logic [P_ADDR_WIDTH-1:0]         A_BIST_FAIL_ADDR,
   input  logic                            A_FI_EN,
   input  logic [P_ADDR_WIDTH-1:0]         A_FI_ADDR,
   input  logic [$clog2(P_DATA_WIDTH)-1:0] A_FI_BIT
);

   localparam logic [P_ADDR_WIDTH:0]   LP_DEPTH = (P_ADDR_WIDTH+1)'(P_DEPTH);
   localparam logic [P_ADDR_WIDTH-1:0] LP_LAST  = P_ADDR_WIDTH'(P_DEPTH - 1);
   localparam logic [P_DATA_WIDTH-1:0] LP_ONE   = P_DATA_WIDTH'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [P_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                      ph_q, ph_d;
   logic [P_DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                      fail_q, fail_d;
   logic [P_ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
   logic                      start_en_q, start_en_d;

   // NOTE: the array has no reset; contents survive A_RST_N and only the
   // declaration gives the time-zero all-zero image.
   logic [P_DATA_WIDTH-1:0]   mem_q [P_DEPTH] = '{default: '0};

   logic                      mem_we;
   logic [P_ADDR_WIDTH-1:0]   mem_wa;
   logic [P_DATA_WIDTH-1:0]   mem_wd;

   logic                      busy;
   logic [P_ADDR_WIDTH-1:0]   rd_addr;
   logic                      in_range;
   logic [P_DATA_WIDTH-1:0]   mem_rd, fmask, merged, rd_word, wt_word;

   logic                      el_up, el_ones;
   state_e                    el_next;
   logic [P_ADDR_WIDTH-1:0]   el_next_addr, el_end;

   logic                      do_cmp;
   logic [P_DATA_WIDTH-1:0]   exp_v;
   logic [P_ADDR_WIDTH-1:0]   cmp_addr;

   logic                      unused_dly;
   assign unused_dly = A_DLY;

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign rd_addr  = busy ? addr_q : A_ADDR;
   assign in_range = {1'b0, rd_addr} < LP_DEPTH;
   assign mem_rd   = in_range ? mem_q[rd_addr] : '0;
   assign fmask    = (A_FI_EN && (rd_addr == A_FI_ADDR)) ? (LP_ONE << A_FI_BIT) : '0;
   assign merged   = (mem_rd & ~A_BM) | (A_DIN & A_BM);
   // The stuck bit is an overlay on the read path; the stored word is untouched.
   assign rd_word  = in_range ? (mem_rd | fmask) : '0;
   assign wt_word  = in_range ? (merged | fmask) : '0;

   // Per-element sweep direction, read background and hand-over target.
   always_comb begin
      el_up        = 1'b1;
      el_ones      = 1'b0;
      el_next      = S_M5;
      el_next_addr = '0;
      case (state_q)
         S_M1: el_next = S_M2;
         S_M2: begin el_ones = 1'b1; el_next = S_M3; el_next_addr = LP_LAST; end
         S_M3: begin el_up = 1'b0;   el_next = S_M4; el_next_addr = LP_LAST; end
         S_M4: begin el_up = 1'b0;   el_ones = 1'b1; el_next = S_M5; end
         default: ;
      endcase
   end
   assign el_end = el_up ? LP_LAST : '0;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ph_d        = ph_q;
      dout_d      = dout_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      start_en_d  = 1'b1;
      mem_we      = 1'b0;
      mem_wa      = addr_q;
      mem_wd      = '0;
      do_cmp      = 1'b0;
      exp_v       = '0;
      cmp_addr    = addr_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (A_MEN && A_WEN) begin
               mem_we = in_range;
               mem_wa = A_ADDR;
               mem_wd = merged;
               if (A_REN) dout_d = wt_word;
            end else if (A_MEN && A_REN) begin
               dout_d = rd_word;
            end
            if (A_BIST_START && start_en_q) begin
               state_d     = S_M0;
               addr_d      = '0;
               ph_d        = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end
         end
         S_M0: begin
            mem_we = 1'b1;
            if (addr_q == LP_LAST) begin
               state_d = S_M1;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + 1'b1;
            end
         end
         S_M1, S_M2, S_M3, S_M4: begin
            if (!ph_q) begin
               dout_d = rd_word;
               ph_d   = 1'b1;
            end else begin
               ph_d   = 1'b0;
               do_cmp = 1'b1;
               exp_v  = el_ones ? '1 : '0;
               mem_we = 1'b1;
               mem_wd = el_ones ? '0 : '1;
               if (addr_q == el_end) begin
                  state_d = el_next;
                  addr_d  = el_next_addr;
               end else begin
                  addr_d  = el_up ? addr_q + 1'b1 : addr_q - 1'b1;
               end
            end
         end
         S_M5: begin
            // Reads are pipelined: this cycle checks the word read one cycle ago.
            dout_d   = rd_word;
            do_cmp   = (addr_q != '0);
            cmp_addr = addr_q - 1'b1;
            if (addr_q == LP_LAST) state_d = S_CHK;
            else                   addr_d  = addr_q + 1'b1;
         end
         S_CHK: begin
            do_cmp   = 1'b1;
            cmp_addr = LP_LAST;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (do_cmp && (dout_q != exp_v)) begin
         fail_d = 1'b1;
         if (!fail_q) fail_addr_d = cmp_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ph_q        <= 1'b0;
         dout_q      <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         start_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ph_q        <= ph_d;
         dout_q      <= dout_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         start_en_q  <= start_en_d;
      end
   end

   always_ff @(posedge A_CLK) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   assign A_DOUT           = dout_q;
   assign A_BIST_BUSY      = busy;
   assign A_BIST_DONE      = (state_q == S_DONE);
   assign A_BIST_FAIL      = fail_q;
   assign A_BIST_FAIL_ADDR = fail_addr_q;

endmodule

// File: doc/sram_1p_bm_mbist.md
Name: sram_1p_bm_mbist

Overview:
- Parametrised single-port SRAM behavioural model with per-bit write mask and write-through.
- Adds an integrated March C- memory BIST engine, non-power-of-two depth and single-bit stuck-at fault injection for verification.
- Used as a drop-in macro model in the OpenROAD SRAM verification flow; the BIST engine runs standalone and replaces the external BIST port mux.

Parameters:
- P_DATA_WIDTH, 24, word width in bits.
- P_ADDR_WIDTH, 14, address width.
- P_DEPTH, 2**P_ADDR_WIDTH, number of words; must be less than or equal to 2**P_ADDR_WIDTH.

Ports:
- A_CLK  in  1  clock, rising edge.
- A_RST_N  in  1  asynchronous active-low reset.
- A_ADDR  in  P_ADDR_WIDTH  functional address.
- A_DIN  in  P_DATA_WIDTH  write data.
- A_BM  in  P_DATA_WIDTH  write bit mask; bit i written when A_BM[i]=1.
- A_MEN  in  1  memory enable.
- A_WEN  in  1  write enable.
- A_REN  in  1  read enable; with A_WEN=1 gives write-through.
- A_DLY  in  1  delay select; no functional effect in the model.
- A_DOUT  out  P_DATA_WIDTH  registered read data.
- A_BIST_START  in  1  one-cycle pulse that starts a March C- run.
- A_BIST_BUSY  out  1  BIST running; functional port ignored while high.
- A_BIST_DONE  out  1  sticky, run complete.
- A_BIST_FAIL  out  1  sticky, at least one miscompare.
- A_BIST_FAIL_ADDR  out  P_ADDR_WIDTH  address of the first miscompare.
- A_FI_EN  in  1  fault-injection enable.
- A_FI_ADDR  in  P_ADDR_WIDTH  faulty word.
- A_FI_BIT  in  $clog2(P_DATA_WIDTH)  faulty bit; stuck-at-1.

Behaviour:
- Reset, asynchronous, while A_RST_N=0:
  - A_DOUT=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FSM returns to IDLE.
  - Memory array is not cleared; it is initialised to 0 only at time zero.
- Functional access (FSM in IDLE or DONE), evaluated at posedge:
  - MEN&WEN: mem[A] <= (mem[A]&~BM)|(DIN&BM). If REN is also high, DOUT <= that same merged value (write-through).
  - MEN&REN&!WEN: DOUT <= mem[A].
  - Otherwise DOUT holds its value.
  - Read latency is 1 cycle.
  - A >= P_DEPTH: writes are dropped; reads return 0.
- Fault injection: while A_FI_EN=1, bit A_FI_BIT of word A_FI_ADDR reads as 1 on every read path, including write-through and BIST reads.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, CHK, DONE.
- Start:
  - START sampled high in IDLE or DONE moves the FSM to M0, clears DONE/FAIL/FAIL_ADDR and sets BUSY.
  - START is ignored while BUSY.
- March elements. Background pattern is all-zeros or all-ones; BIST forces BM to all-ones.
  - M0 up: w0, 1 cycle per address.
  - M1 up: r0,w1.
  - M2 up: r1,w0.
  - M3 down: r0,w1.
  - M4 down: r1,w0.
  - M5 up: r0.
  - Two-op elements take 2 cycles per address: read cycle, then write cycle. The compare is done in the write cycle against the registered DOUT.
  - M5 issues one read per cycle; each compare is made on the next cycle.
  - CHK performs the final M5 compare, then moves to DONE.
- Addressing:
  - Up elements sweep 0..P_DEPTH-1; down elements sweep P_DEPTH-1..0.
  - The address counter wraps to the start value on each element change.
- Timing: DONE rises, and BUSY falls, after edge k+10*P_DEPTH+1, where k is the START sampling edge.
- Miscompare: FAIL is set. FAIL_ADDR captures the failing address only on the first miscompare; later miscompares leave it unchanged.
- A_DOUT during BIST shows the engine's read data. Functional inputs are ignored while BUSY.
- Reset mid-BIST aborts to IDLE with the outputs listed above. Memory keeps partially written patterns.
- A START pulse coincident with reset deassertion is ignored.

Test Plan:
- P_DEPTH=16, write A=3 DIN=0xABCDEF BM=0xFFFFFF, then write A=3 DIN=0 BM=0x0000FF, then read -> DOUT=0xABCD00 one cycle after the read edge.
- Write-through: WEN=REN=1, A=5, DIN=0x123456, BM=0xFF0000, previous mem[5]=0 -> DOUT=0x120000 on the same edge; mem[5]=0x120000.
- P_DEPTH=16, no fault, pulse START -> BUSY for 161 cycles, DONE=1, FAIL=0. Later functional read of any word returns 0x000000.
- P_DEPTH=12 (non-power-of-two), FI_EN=1, FI_ADDR=7, FI_BIT=4, START -> DONE after 121 cycles, FAIL=1, FAIL_ADDR=7. A second START clears FAIL during the run and sets it again.
- Assert A_RST_N=0 at cycle 50 of a run -> BUSY, DONE, FAIL and DOUT are 0 immediately. A new START completes normally.
- START pulsed while BUSY -> ignored; DONE timing is unchanged. Functional write during BUSY to A=2 -> mem[2] still 0 after DONE.
